// File: rtl/rshift_mux_unit.sv
// Registered barrel right-shift/rotate unit built from 2:1 bit muxes and 3:1 fill muxes.
// Define ROR_EN to build rotate-right for SETPIN=00; otherwise SETPIN=00 acts as SRL.

module rshift_mux2 (
    input  logic sel,
    input  logic in0,
    input  logic in1,
    output logic out
);
    assign out = sel ? in1 : in0;
endmodule

module rshift_fill_mux3 (
    input  logic [1:0] sel,
    input  logic       in0,
    input  logic       in1,
    input  logic       in2,
    output logic       out
);
    always_comb begin
        out = in1;
        case (sel)
            2'b00:   out = in0;
            2'b11:   out = in2;
            default: out = in1;
        endcase
    end
endmodule

module rshift_mux_unit #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             IN_VALID,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    input  logic [1:0]       SETPIN,
    output logic             OUT_VALID,
    output logic [WIDTH-1:0] OUTPUT
);
    localparam int LOG = $clog2(WIDTH);

    logic [WIDTH-1:0] stage [LOG+1];
    logic             hi;
    logic             is_ror;
    logic             is_sra;
    logic [WIDTH-1:0] result;

    assign stage[0] = DATA1;
    assign hi       = |DATA2[WIDTH-1:LOG];
    assign is_sra   = (SETPIN == 2'b11);
`ifdef ROR_EN
    assign is_ror   = (SETPIN == 2'b00);
`else
    assign is_ror   = 1'b0;
`endif

    for (genvar k = 0; k < LOG; k++) begin : g_layer
        localparam int SH = 1 << k;
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            logic src;
            if (i + SH < WIDTH) begin : g_inner
                assign src = stage[k][i+SH];
            end else begin : g_fill
`ifdef ROR_EN
                rshift_fill_mux3 u_fill (
                    .sel (SETPIN),
                    .in0 (stage[k][i+SH-WIDTH]),
                    .in1 (1'b0),
                    .in2 (stage[k][WIDTH-1]),
                    .out (src)
                );
`else
                // No wrap wiring: SETPIN=00 selects the constant-zero in0
                rshift_fill_mux3 u_fill (
                    .sel (SETPIN),
                    .in0 (1'b0),
                    .in1 (1'b0),
                    .in2 (stage[k][WIDTH-1]),
                    .out (src)
                );
`endif
            end
            rshift_mux2 u_mux (
                .sel (DATA2[k]),
                .in0 (stage[k][i]),
                .in1 (src),
                .out (stage[k+1][i])
            );
        end
    end

    // Out-of-range shift amounts saturate; rotate just uses the low bits
    always_comb begin
        result = stage[LOG];
        if (hi && !is_ror)
            result = {WIDTH{is_sra & DATA1[WIDTH-1]}};
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            OUTPUT    <= '0;
            OUT_VALID <= 1'b0;
        end else begin
            OUT_VALID <= IN_VALID;
            if (IN_VALID)
                OUTPUT <= result;
        end
    end
endmodule

// File: tb/tb_rshift_mux_unit.sv
// Directed self-checking bench for rshift_mux_unit (WIDTH=8); rotate vectors run when ROR_EN is defined.

module tb_rshift_mux_unit;
    logic       CLK;
    logic       RESET;
    logic       IN_VALID;
    logic [7:0] DATA1;
    logic [7:0] DATA2;
    logic [1:0] SETPIN;
    logic       OUT_VALID;
    logic [7:0] OUTPUT;

    int n_checks = 0;
    int n_pass   = 0;

    rshift_mux_unit #(.WIDTH(8)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .IN_VALID  (IN_VALID),
        .DATA1     (DATA1),
        .DATA2     (DATA2),
        .SETPIN    (SETPIN),
        .OUT_VALID (OUT_VALID),
        .OUTPUT    (OUTPUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [7:0] d1, input logic [7:0] d2, input logic [1:0] sp);
        IN_VALID = v;
        DATA1    = d1;
        DATA2    = d2;
        SETPIN   = sp;
    endtask

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    // Apply one valid operation and check the registered result one edge later
    task automatic op(input string tag, input logic [7:0] d1, input logic [7:0] d2,
                      input logic [1:0] sp, input logic [7:0] exp);
        drive(1'b1, d1, d2, sp);
        step();
        check({tag, "_out"}, OUTPUT, exp);
        check({tag, "_vld"}, OUT_VALID, 1'b1);
    endtask

    initial begin
        RESET = 1'b1;
        drive(1'b0, 8'h00, 8'h00, 2'b00);
        @(negedge CLK);

        RESET = 1'b0;
        drive(1'b1, 8'hFF, 8'h00, 2'b10);
        step();
        check("reset_out", OUTPUT, 8'h00);
        check("reset_vld", OUT_VALID, 1'b0);
        RESET = 1'b1;

`ifdef ROR_EN
        op("ror_99_1",  8'h99, 8'd1,  2'b00, 8'hCC);
        op("ror_c3_3",  8'hC3, 8'd3,  2'b00, 8'h78);
        op("ror_f1_2",  8'hF1, 8'd2,  2'b00, 8'h7C);
        op("ror_99_0",  8'h99, 8'd0,  2'b00, 8'h99);
        op("ror_f1_23", 8'hF1, 8'h23, 2'b00, 8'h3E);
`else
        op("m00_99_1",  8'h99, 8'd1,  2'b00, 8'h4C);
        op("m00_f1_23", 8'hF1, 8'h23, 2'b00, 8'h00);
        op("m00_99_0",  8'h99, 8'd0,  2'b00, 8'h99);
`endif

        op("sra_e0_3",  8'hE0, 8'd3,  2'b11, 8'hFC);
        op("sra_80_7",  8'h80, 8'd7,  2'b11, 8'hFF);
        op("sra_80_48", 8'h80, 8'h48, 2'b11, 8'hFF);
        op("sra_99_1",  8'h99, 8'd1,  2'b11, 8'hCC);
        op("sra_7f_10", 8'h7F, 8'h10, 2'b11, 8'h00);

        op("srl_f1_2",  8'hF1, 8'd2,  2'b10, 8'h3C);
        op("srl_f1_23", 8'hF1, 8'h23, 2'b01, 8'h00);
        op("srl01_80_7", 8'h80, 8'd7, 2'b01, 8'h01);
        op("srl_99_0",  8'h99, 8'd0,  2'b10, 8'h99);

        // Back-to-back stream, then a bubble, then reset mid-stream
        op("pipe0", 8'hF0, 8'd4, 2'b10, 8'h0F);
        op("pipe1", 8'h81, 8'd1, 2'b11, 8'hC0);
        op("pipe2", 8'hAA, 8'd6, 2'b10, 8'h02);
        drive(1'b0, 8'hFF, 8'd0, 2'b10);
        step();
        check("idle_vld", OUT_VALID, 1'b0);
        check("idle_hold", OUTPUT, 8'h02);
        step();
        check("idle2_hold", OUTPUT, 8'h02);

        op("pre_rst", 8'h40, 8'd2, 2'b10, 8'h10);
        RESET = 1'b0;
        drive(1'b1, 8'hFF, 8'd1, 2'b10);
        step();
        check("midrst_out", OUTPUT, 8'h00);
        check("midrst_vld", OUT_VALID, 1'b0);
        RESET = 1'b1;
        op("post_rst", 8'hFF, 8'd1, 2'b10, 8'h7F);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
